// File: rtl/evt2_decoder.sv
// EVT 2.0 word decoder: pops words from the input FIFO, tracks the TIME_HIGH base, emits CD events.
// Latency: one FIFO pop every two cycles at most; an event appears two edges after the pop that fetched it.
// Backpressure: the output register holds while ev_valid_o && !ev_ready_i, and no pop is issued until it frees.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   fifo_empty_i / fifo_rd_en_o   FIFO status and pop request
//   fifo_rd_data_i                popped word, valid the cycle after the pop
//   ev_valid_o / ev_ready_i       event stream handshake
//   ev_x_o, ev_y_o, ev_pol_o, ev_ts_o   event payload
//   time_valid_o                  a TIME_HIGH word has been seen since reset
//   cnt_events_o, cnt_dropped_o   saturating statistics counters
module evt2_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int SENSOR_W   = 320,
  parameter int SENSOR_H   = 320,
  parameter int X_BITS     = 9,
  parameter int Y_BITS     = 9,
  parameter int TS_WIDTH   = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  ev_valid_o,
  input  logic                  ev_ready_i,
  output logic [X_BITS-1:0]     ev_x_o,
  output logic [Y_BITS-1:0]     ev_y_o,
  output logic                  ev_pol_o,
  output logic [TS_WIDTH-1:0]   ev_ts_o,
  output logic                  time_valid_o,
  output logic [CNT_WIDTH-1:0]  cnt_events_o,
  output logic [CNT_WIDTH-1:0]  cnt_dropped_o
);

  localparam logic [10:0] X_LIM = 11'(SENSOR_W);
  localparam logic [10:0] Y_LIM = 11'(SENSOR_H);

  typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_e;

  state_e state_q, state_d;

  logic                 ev_valid_q, ev_valid_d;
  logic [X_BITS-1:0]    ev_x_q, ev_x_d;
  logic [Y_BITS-1:0]    ev_y_q, ev_y_d;
  logic                 ev_pol_q, ev_pol_d;
  logic [TS_WIDTH-1:0]  ev_ts_q, ev_ts_d;
  logic [27:0]          time_high_q, time_high_d;
  logic                 time_valid_q, time_valid_d;
  logic [CNT_WIDTH-1:0] cnt_ev_q, cnt_ev_d;
  logic [CNT_WIDTH-1:0] cnt_drop_q, cnt_drop_d;

  logic        decode_en;
  logic [3:0]  w_type;
  logic [5:0]  w_ts_lsb;
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [33:0] w_ts_full;
  logic        is_th, is_cd, load_ev, drop_ev;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fifo_rd_en_o) state_d = S_FETCH;
      S_FETCH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A pop is only issued when the output register will be free at the next
  // edge, so the word decoded in FETCH can always be loaded. Reset gates the
  // pop so no word is lost while the block is being cleared.
  always_comb begin
    fifo_rd_en_o = 1'b0;
    decode_en    = 1'b0;
    case (state_q)
      S_IDLE:  fifo_rd_en_o = !rst_i && !fifo_empty_i && (!ev_valid_q || ev_ready_i);
      S_FETCH: decode_en    = 1'b1;
      default: ;
    endcase
  end

  // ---------------- word decode ----------------
  assign w_type    = fifo_rd_data_i[31:28];
  assign w_ts_lsb  = fifo_rd_data_i[27:22];
  assign w_x       = fifo_rd_data_i[21:11];
  assign w_y       = fifo_rd_data_i[10:0];
  assign w_ts_full = {time_high_q, w_ts_lsb};

  assign is_th   = decode_en && (w_type == 4'h8);
  assign is_cd   = decode_en && (w_type == 4'h0 || w_type == 4'h1);
  assign load_ev = is_cd && time_valid_q && (w_x < X_LIM) && (w_y < Y_LIM);
  assign drop_ev = is_cd && !load_ev;

  always_comb begin
    ev_valid_d   = ev_valid_q;
    ev_x_d       = ev_x_q;
    ev_y_d       = ev_y_q;
    ev_pol_d     = ev_pol_q;
    ev_ts_d      = ev_ts_q;
    time_high_d  = time_high_q;
    time_valid_d = time_valid_q;
    cnt_ev_d     = cnt_ev_q;
    cnt_drop_d   = cnt_drop_q;

    if (ev_valid_q && ev_ready_i) ev_valid_d = 1'b0;

    if (is_th) begin
      time_high_d  = fifo_rd_data_i[27:0];
      time_valid_d = 1'b1;
    end

    if (load_ev) begin
      ev_valid_d = 1'b1;
      ev_x_d     = w_x[X_BITS-1:0];
      ev_y_d     = w_y[Y_BITS-1:0];
      ev_pol_d   = w_type[0];
      ev_ts_d    = w_ts_full[TS_WIDTH-1:0];
      if (cnt_ev_q != '1) cnt_ev_d = cnt_ev_q + 1'b1;
    end

    if (drop_ev && cnt_drop_q != '1) cnt_drop_d = cnt_drop_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ev_valid_q   <= 1'b0;
      ev_x_q       <= '0;
      ev_y_q       <= '0;
      ev_pol_q     <= 1'b0;
      ev_ts_q      <= '0;
      time_high_q  <= '0;
      time_valid_q <= 1'b0;
      cnt_ev_q     <= '0;
      cnt_drop_q   <= '0;
    end else begin
      ev_valid_q   <= ev_valid_d;
      ev_x_q       <= ev_x_d;
      ev_y_q       <= ev_y_d;
      ev_pol_q     <= ev_pol_d;
      ev_ts_q      <= ev_ts_d;
      time_high_q  <= time_high_d;
      time_valid_q <= time_valid_d;
      cnt_ev_q     <= cnt_ev_d;
      cnt_drop_q   <= cnt_drop_d;
    end
  end

  assign ev_valid_o    = ev_valid_q;
  assign ev_x_o        = ev_x_q;
  assign ev_y_o        = ev_y_q;
  assign ev_pol_o      = ev_pol_q;
  assign ev_ts_o       = ev_ts_q;
  assign time_valid_o  = time_valid_q;
  assign cnt_events_o  = cnt_ev_q;
  assign cnt_dropped_o = cnt_drop_q;

endmodule

// File: tb/tb_evt2_decoder.sv
// Bench for evt2_decoder: FIFO model, directed scenarios and a randomized run
// checked against a word-by-word reference of the EVT 2.0 decoding rules.
// Inputs change on the falling edge; outputs are sampled just after it.
module tb_evt2_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        ev_valid;
  logic        ev_ready;
  logic [8:0]  ev_x;
  logic [8:0]  ev_y;
  logic        ev_pol;
  logic [23:0] ev_ts;
  logic        time_valid;
  logic [15:0] cnt_events;
  logic [15:0] cnt_dropped;

  evt2_decoder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .ev_valid_o     (ev_valid),
    .ev_ready_i     (ev_ready),
    .ev_x_o         (ev_x),
    .ev_y_o         (ev_y),
    .ev_pol_o       (ev_pol),
    .ev_ts_o        (ev_ts),
    .time_valid_o   (time_valid),
    .cnt_events_o   (cnt_events),
    .cnt_dropped_o  (cnt_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic        pol;
    logic [23:0] ts;
  } ev_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] fq[$];
  ev_t         exp_q[$];
  longint      m_th;
  bit          m_tv;
  int          m_ev;
  int          m_drop;

  function automatic void model_reset();
    m_th = 0; m_tv = 0; m_ev = 0; m_drop = 0;
    exp_q.delete();
  endfunction

  function automatic void model_word(input logic [31:0] w);
    int     t, x, y, lsb;
    longint full;
    ev_t    e;
    t   = int'(w >> 28);
    x   = int'((w >> 11) & 32'h7FF);
    y   = int'(w & 32'h7FF);
    lsb = int'((w >> 22) & 32'h3F);
    if (t == 8) begin
      m_th = longint'(w & 32'h0FFF_FFFF);
      m_tv = 1;
    end else if (t == 0 || t == 1) begin
      if (m_tv && x < 320 && y < 320) begin
        full  = m_th * 64 + lsb;
        e.x   = 9'(x);
        e.y   = 9'(y);
        e.pol = (t == 1);
        e.ts  = 24'(full % (longint'(1) << 24));
        exp_q.push_back(e);
        if (m_ev < 65535) m_ev++;
      end else if (m_drop < 65535) m_drop++;
    end
  endfunction

  function automatic logic [31:0] mk_cd(input bit pol, input int lsb, input int x, input int y);
    return {3'b000, pol, 6'(lsb), 11'(x), 11'(y)};
  endfunction

  // ---------------- per-cycle driver / monitor ----------------
  bit          held = 0;
  logic [43:0] held_val;
  ev_t         last_ev;
  int          n_pops = 0;

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
    model_word(w);
  endtask

  task automatic step();
    bit          pop;
    logic [43:0] cur;
    #1;
    pop = fifo_rd_en;
    cur = {ev_valid, ev_x, ev_y, ev_pol, ev_ts};
    if (held) chk("hold_stable", cur, held_val);
    held     = ev_valid && !ev_ready;
    held_val = cur;
    if (held) chk("rd_en_while_held", fifo_rd_en, 0);
    if (ev_valid && ev_ready) begin
      if (exp_q.size() == 0) chk("unexpected_event", cur, 0);
      else chk("event", {ev_x, ev_y, ev_pol, ev_ts}, exp_q.pop_front());
      last_ev = '{x: ev_x, y: ev_y, pol: ev_pol, ts: ev_ts};
    end
    @(posedge clk);
    #1;
    if (pop) begin
      n_pops++;
      if (fq.size() == 0) chk("pop_when_empty", 1, 0);
      else fifo_rd_data = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int idle;
    idle     = 0;
    ev_ready = 1'b1;
    for (int i = 0; i < budget && idle < 3; i++) begin
      step();
      if (fq.size() == 0 && !ev_valid && !fifo_rd_en) idle++;
      else idle = 0;
    end
    chk("drain_done", (idle >= 3), 1);
    chk("all_events_seen", exp_q.size(), 0);
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_cnt_events"}, cnt_events, m_ev);
    chk({tag, "_cnt_dropped"}, cnt_dropped, m_drop);
    chk({tag, "_time_valid"}, time_valid, m_tv);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    fq.delete();
    fifo_empty = 1'b1;
    model_reset();
    step();
    held = 0;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_outputs", {ev_valid, ev_x, ev_y, ev_pol, ev_ts}, 0);
    chk("rst_time_valid", time_valid, 0);
    chk("rst_counters", {cnt_events, cnt_dropped}, 0);
    rst = 1'b0;
  endtask

  initial begin
    int base, cyc;
    logic [31:0] w;

    rst          = 1'b1;
    fifo_empty   = 1'b1;
    fifo_rd_data = 32'h0;
    ev_ready     = 1'b1;
    model_reset();
    @(negedge clk);
    apply_reset();

    // T1: CD before any time base is dropped
    push(32'h1143_20C8);
    drain(50);
    chk("t1_dropped", cnt_dropped, 1);
    check_counters("t1");

    // T2: time base then CD
    push(32'h8000_0001);
    push(32'h1143_20C8);
    drain(50);
    chk("t2_x", last_ev.x, 100);
    chk("t2_y", last_ev.y, 200);
    chk("t2_pol", last_ev.pol, 1);
    chk("t2_ts", last_ev.ts, 69);
    chk("t2_cnt_events", cnt_events, 1);
    check_counters("t2");

    // T3: out-of-bounds CD_OFF dropped, next valid word delivered
    push(mk_cd(0, 3, 400, 10));
    push(mk_cd(0, 7, 319, 0));
    push(mk_cd(1, 9, 5, 320));
    push(mk_cd(1, 63, 0, 319));
    drain(50);
    check_counters("t3");

    // T4: backpressure holds one event and stops pops
    ev_ready = 1'b0;
    push(mk_cd(1, 1, 10, 11));
    push(mk_cd(0, 2, 20, 21));
    push(mk_cd(1, 3, 30, 31));
    for (int i = 0; i < 10; i++) step();
    chk("t4_held_valid", ev_valid, 1);
    chk("t4_fifo_left", fq.size(), 2);
    drain(50);
    check_counters("t4");

    // T5: non-CD, non-time words consumed silently
    push(32'hA000_0000);
    push(32'hE000_0000);
    push(32'hF000_0000);
    push(32'h3123_4567);
    drain(50);
    chk("t5_fifo_drained", fq.size(), 0);
    check_counters("t5");

    // T6: reset while a CD word is in FETCH
    ev_ready = 1'b1;
    base = n_pops;
    push(32'h8000_0ABC);
    push(mk_cd(1, 4, 1, 2));
    push(mk_cd(0, 5, 3, 4));
    push(mk_cd(1, 6, 5, 6));
    cyc = 0;
    while (n_pops < base + 2 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("t6_reached_fetch", n_pops - base, 2);
    apply_reset();
    push(mk_cd(1, 8, 50, 60));
    drain(50);
    chk("t6_dropped_after_rst", cnt_dropped, 1);
    check_counters("t6a");
    push(32'h8000_0002);
    push(mk_cd(1, 8, 50, 60));
    drain(50);
    check_counters("t6b");

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      ev_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 9))
          0, 1:    w = {4'h8, 28'($urandom)};
          2:       w = {4'($urandom_range(2, 15)), 28'($urandom)};
          3:       w = {3'b000, 1'($urandom), 6'($urandom), 11'($urandom), 11'($urandom)};
          default: w = mk_cd(1'($urandom), int'($urandom_range(0, 63)),
                             int'($urandom_range(0, 359)), int'($urandom_range(0, 359)));
        endcase
        push(w);
      end
      step();
    end
    drain(200);
    check_counters("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
